// File: rtl/lcd_text_driver.sv
// HD44780 4-bit write-only text driver: power-up init, then refreshes a 2x16 frame from a shadow of strdata.
// Optional: define LCD_REFRESH_CLEAR_EN to send a clear (0x01) at the start of every frame.
module lcd_text_driver #(
  parameter int CYC_US = 50,
  parameter int E_CYC  = 12
) (
  input  logic         CCLK,
  input  logic         rst_n,
  input  logic         cls,
  input  logic [255:0] strdata,
  output logic         LCDE,
  output logic         LCDRS,
  output logic         LCDRW,
  output logic [3:0]   LCDDAT,
  output logic         busy
);
  localparam int CW = $clog2(15000*CYC_US + 1);
  localparam logic [CW-1:0] T_PWR  = CW'(15000*CYC_US - 1);
  localparam logic [CW-1:0] T_US   = CW'(CYC_US - 1);
  localparam logic [CW-1:0] T_E    = CW'(E_CYC - 1);
  localparam logic [CW-1:0] G40    = CW'(40*CYC_US - 1);
  localparam logic [CW-1:0] G100   = CW'(100*CYC_US - 1);
  localparam logic [CW-1:0] G2000  = CW'(2000*CYC_US - 1);
  localparam logic [CW-1:0] G4100  = CW'(4100*CYC_US - 1);

  typedef enum logic [3:0] {PWR_WAIT, INIT, IDLE, LOAD, CLR, ADDR1, LINE1, ADDR2, LINE2} state_e;
  typedef enum logic [2:0] {N_IDLE, SETUP, E_HI, E_LO, GAP} nib_e;

  state_e          st_q;
  nib_e            nst_q;
  logic [CW-1:0]   cnt_q, gap_q;
  logic [3:0]      step_q, idx_q, lo_nib_q, dat_q;
  logic            lo_pend_q, rs_q, lcde_q, sent_q, pending_q;
  logic [255:0]    shadow_q;

  // Launch request to the nibble engine, decoded from the main state.
  logic            go, go_byte, go_rs;
  logic [7:0]      go_val;
  logic [CW-1:0]   go_gap;
  logic [4:0]      cidx;
  logic [7:0]      ch;

  assign cidx = {st_q == LINE2, idx_q};
  assign ch   = shadow_q[{~cidx, 3'b000} +: 8];

  always_comb begin
    go      = 1'b0;
    go_byte = 1'b1;
    go_rs   = 1'b0;
    go_val  = 8'h00;
    go_gap  = G40;
    case (st_q)
      INIT: if (nst_q == N_IDLE && step_q < 4'd8) begin
        go = 1'b1;
        case (step_q)
          4'd0:    begin go_byte = 1'b0; go_val = 8'h03; go_gap = G4100; end
          4'd1:    begin go_byte = 1'b0; go_val = 8'h03; go_gap = G100;  end
          4'd2:    begin go_byte = 1'b0; go_val = 8'h03; go_gap = G100;  end
          4'd3:    begin go_byte = 1'b0; go_val = 8'h02; go_gap = G100;  end
          4'd4:    go_val = 8'h28;
          4'd5:    go_val = 8'h0C;
          4'd6:    go_val = 8'h06;
          default: begin go_val = 8'h01; go_gap = G2000; end
        endcase
      end
      CLR:   if (nst_q == N_IDLE && !sent_q) begin go = 1'b1; go_val = 8'h01; go_gap = G2000; end
      ADDR1: if (nst_q == N_IDLE && !sent_q) begin go = 1'b1; go_val = 8'h80; end
      ADDR2: if (nst_q == N_IDLE && !sent_q) begin go = 1'b1; go_val = 8'hC0; end
      LINE1, LINE2: if (nst_q == N_IDLE && !sent_q) begin go = 1'b1; go_rs = 1'b1; go_val = ch; end
      default: ;
    endcase
  end

  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= PWR_WAIT;
      nst_q     <= N_IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      step_q    <= '0;
      idx_q     <= '0;
      lo_nib_q  <= '0;
      dat_q     <= '0;
      lo_pend_q <= 1'b0;
      rs_q      <= 1'b0;
      lcde_q    <= 1'b0;
      sent_q    <= 1'b0;
      pending_q <= 1'b1;
      shadow_q  <= '0;
    end else begin
      pending_q <= pending_q | cls;

      // Nibble engine: setup, enable pulse, 1 us hold, then either the low nibble or the post gap.
      case (nst_q)
        N_IDLE: if (go) begin
          lo_nib_q  <= go_val[3:0];
          lo_pend_q <= go_byte;
          gap_q     <= go_gap;
          rs_q      <= go_rs;
          dat_q     <= go_byte ? go_val[7:4] : go_val[3:0];
          cnt_q     <= '0;
          nst_q     <= SETUP;
        end
        SETUP: if (cnt_q == CW'(1)) begin
          cnt_q <= '0; lcde_q <= 1'b1; nst_q <= E_HI;
        end else cnt_q <= cnt_q + 1'b1;
        E_HI: if (cnt_q == T_E) begin
          cnt_q <= '0; lcde_q <= 1'b0; nst_q <= E_LO;
        end else cnt_q <= cnt_q + 1'b1;
        E_LO: if (cnt_q == T_US) begin
          cnt_q <= '0;
          if (lo_pend_q) begin
            lo_pend_q <= 1'b0; dat_q <= lo_nib_q; nst_q <= SETUP;
          end else nst_q <= GAP;
        end else cnt_q <= cnt_q + 1'b1;
        GAP: if (cnt_q == gap_q) begin
          cnt_q <= '0; nst_q <= N_IDLE;
        end else cnt_q <= cnt_q + 1'b1;
        default: nst_q <= N_IDLE;
      endcase

      case (st_q)
        PWR_WAIT: if (cnt_q == T_PWR) begin
          cnt_q <= '0; st_q <= INIT;
        end else cnt_q <= cnt_q + 1'b1;
        INIT: begin
          if (go) step_q <= step_q + 1'b1;
          else if (nst_q == N_IDLE && step_q == 4'd8) st_q <= IDLE;
        end
        IDLE: if (pending_q) st_q <= LOAD;
        LOAD: begin
          shadow_q  <= strdata;
          pending_q <= cls;
          sent_q    <= 1'b0;
          idx_q     <= '0;
`ifdef LCD_REFRESH_CLEAR_EN
          st_q <= CLR;
`else
          st_q <= ADDR1;
`endif
        end
        CLR, ADDR1, ADDR2: begin
          if (go) sent_q <= 1'b1;
          else if (nst_q == N_IDLE && sent_q) begin
            sent_q <= 1'b0;
            st_q   <= (st_q == CLR) ? ADDR1 : (st_q == ADDR1) ? LINE1 : LINE2;
          end
        end
        LINE1, LINE2: begin
          if (go) sent_q <= 1'b1;
          else if (nst_q == N_IDLE && sent_q) begin
            sent_q <= 1'b0;
            idx_q  <= idx_q + 1'b1;
            if (idx_q == 4'd15) st_q <= (st_q == LINE1) ? ADDR2 : IDLE;
          end
        end
        default: st_q <= PWR_WAIT;
      endcase
    end
  end

  assign LCDE   = lcde_q;
  assign LCDRS  = rs_q;
  assign LCDRW  = 1'b0;
  assign LCDDAT = dat_q;
  assign busy   = !(st_q == IDLE && !pending_q);
endmodule
